// File: rtl/ram_sp_sr_sw_be_pkg.sv
// ram_sp_sr_sw_be_pkg: shared widths and clear-FSM state encoding for the single-port byte-enable RAM
package ram_sp_sr_sw_be_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} clr_state_t;
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: READ_LATENCY-deep read data/valid pipeline, valid bits cleared asynchronously
module ram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  logic [READ_LATENCY-1:0] v;
  logic [DATA_WIDTH-1:0]   d [READ_LATENCY];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else v <= READ_LATENCY'({v, in_valid});
  always_ff @(posedge clk) begin
    d[0] <= in_data;
    for (int i = 1; i < READ_LATENCY; i++) d[i] <= d[i-1];
  end
  assign out_valid = v[READ_LATENCY-1];
  assign out_data  = d[READ_LATENCY-1];
endmodule

// File: rtl/ram_sp_sr_sw_be.sv
// ram_sp_sr_sw_be: single-port RAM with byte-lane writes, pipelined tri-state reads and zero-fill after reset
module ram_sp_sr_sw_be
  import ram_sp_sr_sw_be_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  inout  wire  [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    cs,
  input  logic                    we,
  input  logic                    oe,
  output logic                    busy,
  output logic                    rd_valid
);
  localparam int NB = DATA_WIDTH / 8;
  clr_state_t            state;
  logic [ADDR_WIDTH:0]   clr_addr;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  in_range, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_word, pipe_data;
  assign busy     = state == CLEAR;
  assign in_range = 32'(address) < RAM_DEPTH;
  assign wr_en    = cs & we & ~busy & in_range;
  assign rd_en    = cs & ~we & oe & ~busy;
  assign rd_word  = in_range ? mem[address] : '0;
  // counter is one bit wider so a full 2^ADDR_WIDTH sweep ends without aliasing to 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == (ADDR_WIDTH+1)'(RAM_DEPTH - 1)) state <= READY;
    end
  always_ff @(posedge clk)
    if (busy) mem[clr_addr[ADDR_WIDTH-1:0]] <= '0;
    else if (wr_en)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[address][8*i +: 8] <= data[8*i +: 8];
  ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_en),
    .in_data  (rd_word),
    .out_valid(rd_valid),
    .out_data (pipe_data)
  );
  assign data = (rd_valid && oe && !we) ? pipe_data : 'z;
endmodule

// File: tb/tb_ram_sp_sr_sw_be.sv
// tb_ram_sp_sr_sw_be: two RAM instances (full depth latency 2, short depth latency 1) against a queue-based model
module tb_ram_sp_sr_sw_be;
  logic        clk = 0, rst_n = 1;
  logic [3:0]  address = 0, be = 0;
  logic        cs = 0, we = 0, oe = 1, drv_en = 0;
  logic [31:0] drv_val = 0;
  wire  [31:0] data_a, data_b;
  logic        busy_a, busy_b, rv_a, rv_b;
  int          tests = 0, fails = 0, cyc = 0;
  assign data_a = drv_en ? drv_val : 'z;
  assign data_b = drv_en ? drv_val : 'z;
  always #5 clk = ~clk;
  ram_sp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data_a), .be(be),
    .cs(cs), .we(we), .oe(oe), .busy(busy_a), .rd_valid(rv_a)
  );
  ram_sp_sr_sw_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(12), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data_b), .be(be),
    .cs(cs), .we(we), .oe(oe), .busy(busy_b), .rd_valid(rv_b)
  );
  function automatic int dep(int k); return k ? 12 : 16; endfunction
  function automatic int lat(int k); return k ? 1 : 2; endfunction
  typedef struct {int k; int due; logic [31:0] d;} rd_t;
  rd_t         q[$];
  logic [31:0] mm [2][16];
  int          bcnt [2];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask
  // a released bus reads as z in four-state simulators and as 0 in two-state ones
  task automatic chk_z(input string n, input logic [31:0] act);
    tests++;
    if (!(act === {32{1'bz}} || act === 32'h0)) begin
      fails++;
      $display("FAIL %s: got %h expected bus released (t=%0t)", n, act, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < 2; k++) begin
        bcnt[k] = dep(k);
        for (int a = 0; a < 16; a++) mm[k][a] = '0;
      end
    end else begin
      cyc++;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].due < cyc) q.delete(i);
      for (int k = 0; k < 2; k++)
        if (bcnt[k] > 0) bcnt[k]--;
        else if (cs && we) begin
          if (int'(address) < dep(k))
            for (int b = 0; b < 4; b++) if (be[b]) mm[k][address][8*b +: 8] = drv_val[8*b +: 8];
        end else if (cs && oe) begin
          rd_t e;
          e.k = k;
          e.due = cyc + lat(k) - 1;
          e.d = int'(address) < dep(k) ? mm[k][address] : 32'h0;
          q.push_back(e);
        end
    end
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      logic ev;
      logic [31:0] ed, dd;
      ev = 0;
      ed = 0;
      foreach (q[i]) if (q[i].k == k && q[i].due == cyc) begin ev = 1; ed = q[i].d; end
      chk($sformatf("busy%0d", k), k ? 32'(busy_b) : 32'(busy_a), 32'(bcnt[k] > 0));
      chk($sformatf("rd_valid%0d", k), k ? 32'(rv_b) : 32'(rv_a), 32'(ev));
      dd = k ? data_b : data_a;
      if (!drv_en) begin
        if (ev && oe && !we) chk($sformatf("rd_data%0d", k), dd, ed);
        else chk_z($sformatf("bus_idle%0d", k), dd);
      end
    end
  task automatic step(); @(posedge clk); #1; endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    address = a; be = b; cs = 1; we = 1; drv_en = 1; drv_val = d;
    step();
    cs = 0; we = 0; drv_en = 0;
  endtask
  task automatic rd(input logic [3:0] a);
    address = a; cs = 1; we = 0; oe = 1; drv_en = 0;
    step();
    cs = 0;
  endtask
  task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string name);
    bit got = 0;
    rd(a);
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (rv_a) begin got = 1; chk(name, data_a, exp); end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: rd_valid never rose within 4 cycles", name);
    end
    step();
  endtask
  task automatic count_clear(output int ca, output int cb, output int cr, input bit wr_busy);
    ca = 0; cb = 0; cr = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      ca += int'(busy_a);
      cb += int'(busy_b);
      cr += int'(rv_a | rv_b);
      step();
      if (wr_busy && i == 5) begin
        address = 0; be = 4'hF; cs = 1; we = 1; drv_en = 1; drv_val = 32'h5555AAAA;
      end else begin
        cs = 0; we = 0; drv_en = 0;
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int ca, cb, cr;
    logic [4:0]  vv;
    logic [31:0] dd [5];
    #2 rst_n = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy_a", 32'(busy_a), 32'h1);
    chk("rst_rv_a", 32'(rv_a), 32'h0);
    chk_z("rst_bus_a", data_a);
    step();
    rst_n = 1;
    count_clear(ca, cb, cr, 0);
    chk("clear_cycles_a", ca, 16);
    chk("clear_cycles_b", cb, 12);
    chk("clear_rd_valid", cr, 0);
    rd_check(0, 32'h0, "clr_addr0");
    rd_check(15, 32'h0, "clr_addr15");
    wr(3, 32'hAABBCCDD, 4'hF);
    wr(3, 32'h11223344, 4'b0101);
    rd_check(3, 32'hAA22CC44, "byte_enable");
    wr(4, 32'h99999999, 4'h0);
    rd_check(4, 32'h0, "be_zero");
    wr(1, 32'h10101010, 4'hF);
    wr(2, 32'h20202020, 4'hF);
    wr(3, 32'h30303030, 4'hF);
    for (int i = 0; i < 5; i++) begin
      address = 4'(i + 1); cs = i < 3; we = 0; oe = 1;
      step();
      @(negedge clk);
      vv[i] = rv_a;
      dd[i] = data_a;
    end
    step();
    chk("lat_valid_pattern", 32'(vv), 32'b01110);
    chk("lat_data0", dd[1], 32'h10101010);
    chk("lat_data1", dd[2], 32'h20202020);
    chk("lat_data2", dd[3], 32'h30303030);
    rd(3);
    oe = 0;
    step();
    @(negedge clk);
    chk("oe_low_rv", 32'(rv_a), 32'h1);
    chk_z("oe_low_bus", data_a);
    step();
    oe = 1;
    @(negedge clk);
    chk("oe_drop_rv", 32'(rv_a), 32'h0);
    chk_z("oe_drop_bus", data_a);
    step();
    rd(2);
    step();
    address = 7; be = 4'hF; cs = 1; we = 1; drv_en = 1; drv_val = 32'hCAFEF00D;
    @(negedge clk);
    chk("wr_res_rv", 32'(rv_a), 32'h1);
    chk("wr_res_bus", data_a, 32'hCAFEF00D);
    step();
    cs = 0; we = 0; drv_en = 0;
    rd_check(7, 32'hCAFEF00D, "wr_res_landed");
    wr(9, 32'h12345678, 4'hF);
    rd_check(9, 32'h12345678, "raw_next_cycle");
    wr(13, 32'hDEADBEEF, 4'hF);
    rd(13);
    @(negedge clk);
    chk("oor_rv_b", 32'(rv_b), 32'h1);
    chk("oor_data_b", data_b, 32'h0);
    @(negedge clk);
    chk("in_range_rv_a", 32'(rv_a), 32'h1);
    chk("in_range_data_a", data_a, 32'hDEADBEEF);
    step();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    repeat (7) step();
    rst_n = 0;
    @(negedge clk);
    chk("midclr_busy_a", 32'(busy_a), 32'h1);
    chk("midclr_rv_a", 32'(rv_a), 32'h0);
    step();
    rst_n = 1;
    count_clear(ca, cb, cr, 1);
    chk("reclear_cycles_a", ca, 16);
    chk("reclear_cycles_b", cb, 12);
    chk("reclear_rd_valid", cr, 0);
    rd_check(0, 32'h0, "busy_write_ignored");
    rd_check(3, 32'h0, "reclear_addr3");
    rd_check(13, 32'h0, "reclear_addr13");
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
